// File: rtl/lcd_pkg.sv
// Shared LCD definitions: controller state encoding and default bus timing,
// common to the read and write paths.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EN_HIGH = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } lcd_state_e;

  localparam int LCD_T_AS     = 3;
  localparam int LCD_T_EH     = 13;
  localparam int LCD_T_AH     = 2;
  localparam int LCD_T_GAP    = 25;
  localparam int LCD_MAX_POLL = 4096;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A phase of n cycles loads n-1: the timer flags expiry while it reads 0.
  function automatic int lcd_ld(input int n);
    return (n > 1) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter that flags expiry on the last cycle of a bus phase.
module lcd_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clk_en_i) begin
      if (load_i)
        cnt_q <= load_val_i;
      else if (cnt_q != '0)
        cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_read_ci.sv
// Custom-instruction LCD read: performs one HD44780-style read cycle, or polls
// the busy flag until it clears or the poll budget runs out.
module lcd_read_ci
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_EH     = LCD_T_EH,
  parameter int T_AH     = LCD_T_AH,
  parameter int T_GAP    = LCD_T_GAP,
  parameter int MAX_POLL = LCD_MAX_POLL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic [31:0] result,
  output logic        done,
  input  logic [7:0]  lcd_data_in,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_bus_rd
);

  localparam int TMAX = lcd_max(lcd_max(T_AS, T_EH), lcd_max(T_AH, T_GAP));
  localparam int CW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(MAX_POLL + 1);

  localparam logic [CW-1:0] AS_LD  = CW'(lcd_ld(T_AS));
  localparam logic [CW-1:0] EH_LD  = CW'(lcd_ld(T_EH));
  localparam logic [CW-1:0] AH_LD  = CW'(lcd_ld(T_AH));
  localparam logic [CW-1:0] GAP_LD = CW'(lcd_ld(T_GAP));

  lcd_state_e    state_q, state_d;
  logic          rs_q, rs_d, poll_q, poll_d;
  logic [7:0]    data_q;
  logic [PW-1:0] poll_cnt_q;
  logic [31:0]   result_q;
  logic          done_q, en_q, rw_q, rs_pin_q, bus_q;
  logic          tmr_expired, tmr_load;
  logic [CW-1:0] tmr_val;
  logic          rd_phase_d, timeout;
  logic [11:0]   cnt_sat;
  logic          unused_dataa;

  assign unused_dataa = ^dataa[31:2];

  // Command bits are captured only when a start is accepted in IDLE.
  assign rs_d   = (state_q == ST_IDLE && start) ? (dataa[0] & ~dataa[1]) : rs_q;
  assign poll_d = (state_q == ST_IDLE && start) ? dataa[1] : poll_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETUP;
      ST_SETUP:   if (tmr_expired) state_d = ST_EN_HIGH;
      ST_EN_HIGH: if (tmr_expired) state_d = ST_HOLD;
      ST_HOLD:
        if (tmr_expired) begin
          if (poll_q && data_q[7] && (poll_cnt_q < PW'(MAX_POLL)))
            state_d = ST_GAP;
          else
            state_d = ST_DONE;
        end
      ST_GAP:     if (tmr_expired) state_d = ST_SETUP;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (!clk_en) state_d = state_q;
  end

  always_comb begin
    tmr_val = '0;
    case (state_d)
      ST_SETUP:   tmr_val = AS_LD;
      ST_EN_HIGH: tmr_val = EH_LD;
      ST_HOLD:    tmr_val = AH_LD;
      ST_GAP:     tmr_val = GAP_LD;
      default:    tmr_val = '0;
    endcase
  end

  assign tmr_load   = clk_en && (state_d != state_q);
  assign rd_phase_d = (state_d == ST_SETUP) || (state_d == ST_EN_HIGH) || (state_d == ST_HOLD);
  assign timeout    = poll_q & data_q[7];
  assign cnt_sat    = (32'(poll_cnt_q) > 32'd4095) ? 12'hFFF : 12'(poll_cnt_q);

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .clk_en_i   (clk_en),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Pins are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rs_q       <= 1'b0;
      poll_q     <= 1'b0;
      data_q     <= '0;
      poll_cnt_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      rw_q       <= 1'b0;
      rs_pin_q   <= 1'b0;
      bus_q      <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      poll_q   <= poll_d;
      rw_q     <= rd_phase_d;
      bus_q    <= rd_phase_d;
      en_q     <= (state_d == ST_EN_HIGH);
      rs_pin_q <= rd_phase_d & rs_d;
      done_q   <= (state_d == ST_DONE);
      if (state_q == ST_EN_HIGH && state_d == ST_HOLD)
        data_q <= lcd_data_in;
      if (state_q == ST_IDLE && state_d == ST_SETUP)
        poll_cnt_q <= poll_d ? PW'(1) : '0;
      else if (state_q == ST_GAP && state_d == ST_SETUP)
        poll_cnt_q <= poll_cnt_q + PW'(1);
      if (state_q == ST_HOLD && state_d == ST_DONE)
        result_q <= {timeout, 3'b000, cnt_sat, 7'b0000000, data_q[7], data_q};
    end
  end

  assign result     = result_q;
  assign done       = done_q;
  assign lcd_rs     = rs_pin_q;
  assign lcd_rw     = rw_q;
  assign lcd_en     = en_q;
  assign lcd_bus_rd = bus_q;

endmodule

// File: tb/tb_lcd_read_ci.sv
// Directed bench for lcd_read_ci: single read, busy polling, timeout, stall,
// mid-read reset and ignored start.
module tb_lcd_read_ci;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic [7:0]  lcd_data_in;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_bus_rd;

  int n_pass = 0;
  int n_total = 0;

  // Per-read observations, cycle k counted from the start cycle (k = 0).
  logic [31:0] rs_vec, rw_vec, en_vec, bus_vec, done_vec;
  logic [31:0] res_at_done;
  logic [7:0]  db_seq[1:15];
  int          rise_cyc[1:15];
  int          pulses, done_cnt, done_cyc, en_qual, rs_seen;

  lcd_read_ci #(.MAX_POLL(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .start       (start),
    .dataa       (dataa),
    .result      (result),
    .done        (done),
    .lcd_data_in (lcd_data_in),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .lcd_bus_rd  (lcd_bus_rd)
  );

  always #5 clk = ~clk;

  task automatic fill_db(input logic [7:0] busy, input int n_busy, input logic [7:0] last);
    for (int i = 1; i <= 15; i++) db_seq[i] = (i <= n_busy) ? busy : last;
  endtask

  // Issues cmd in cycle 0 and samples every cycle at the falling edge.
  task automatic run_read(input logic [31:0] cmd, input int ncyc,
                          input int stall_from, input int stall_len, input int restart_at);
    logic prev_en;
    rs_vec = '0; rw_vec = '0; en_vec = '0; bus_vec = '0; done_vec = '0;
    res_at_done = '0; pulses = 0; done_cnt = 0; done_cyc = -1; en_qual = 0; rs_seen = 0;
    for (int i = 1; i <= 15; i++) rise_cyc[i] = -1;
    prev_en = 1'b0;
    lcd_data_in = db_seq[1];
    @(negedge clk);
    dataa = cmd; start = 1'b1; clk_en = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (lcd_en && !prev_en) begin
        pulses++;
        if (pulses <= 15) begin
          rise_cyc[pulses] = k;
          lcd_data_in = db_seq[pulses];
        end
      end
      prev_en = lcd_en;
      if (lcd_en && clk_en) en_qual++;
      if (lcd_rs) rs_seen++;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = k;
          res_at_done = result;
        end
      end
      if (k < 32) begin
        rs_vec[k] = lcd_rs; rw_vec[k] = lcd_rw; en_vec[k] = lcd_en;
        bus_vec[k] = lcd_bus_rd; done_vec[k] = done;
      end
      start  = (k + 1 == restart_at);
      clk_en = !((k + 1 >= stall_from) && (k + 1 < stall_from + stall_len));
    end
    start = 1'b0; clk_en = 1'b1; dataa = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; dataa = '0; lcd_data_in = '0;
    repeat (3) @(negedge clk);
    n_total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if ({lcd_en, lcd_rw, lcd_rs, lcd_bus_rd} !== 4'b0000)
      $display("FAIL reset_pins: got %b expected 0000", {lcd_en, lcd_rw, lcd_rs, lcd_bus_rd}); else n_pass++;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if ({lcd_en, lcd_rw, lcd_rs, lcd_bus_rd, done} !== 5'b00000)
      $display("FAIL idle_pins: got %b expected 00000", {lcd_en, lcd_rw, lcd_rs, lcd_bus_rd, done}); else n_pass++;
  endtask

  task automatic test_single_read;
    fill_db(8'h41, 0, 8'h41);
    run_read(32'h1, 40, 0, 0, 0);
    n_total++; if (rs_vec !== 32'h0007_FFFE) $display("FAIL single_rs: got %h expected 0007fffe", rs_vec); else n_pass++;
    n_total++; if (rw_vec !== 32'h0007_FFFE) $display("FAIL single_rw: got %h expected 0007fffe", rw_vec); else n_pass++;
    n_total++; if (bus_vec !== 32'h0007_FFFE) $display("FAIL single_bus_rd: got %h expected 0007fffe", bus_vec); else n_pass++;
    n_total++; if (en_vec !== 32'h0001_FFF0) $display("FAIL single_en: got %h expected 0001fff0", en_vec); else n_pass++;
    n_total++; if (done_vec !== 32'h0008_0000) $display("FAIL single_done: got %h expected 00080000", done_vec); else n_pass++;
    n_total++; if (res_at_done !== 32'h0000_0041) $display("FAIL single_result: got %h expected 00000041", res_at_done); else n_pass++;
    n_total++; if (result !== 32'h0000_0041) $display("FAIL single_result_held: got %h expected 00000041", result); else n_pass++;
  endtask

  task automatic test_busy_poll;
    fill_db(8'h80, 3, 8'h05);
    run_read(32'h2, 170, 0, 0, 0);
    n_total++; if (pulses !== 4) $display("FAIL poll_pulses: got %0d expected 4", pulses); else n_pass++;
    n_total++; if ({rise_cyc[1], rise_cyc[2], rise_cyc[3], rise_cyc[4]} !== {32'd4, 32'd47, 32'd90, 32'd133})
      $display("FAIL poll_rise_cycles: got %0d %0d %0d %0d expected 4 47 90 133",
               rise_cyc[1], rise_cyc[2], rise_cyc[3], rise_cyc[4]); else n_pass++;
    n_total++; if (done_cyc !== 148) $display("FAIL poll_done_cyc: got %0d expected 148", done_cyc); else n_pass++;
    n_total++; if (res_at_done !== 32'h0004_0005) $display("FAIL poll_result: got %h expected 00040005", res_at_done); else n_pass++;
    n_total++; if (rs_seen !== 0) $display("FAIL poll_rs: got %0d rs-high cycles expected 0", rs_seen); else n_pass++;
  endtask

  task automatic test_timeout;
    fill_db(8'hFF, 15, 8'hFF);
    run_read(32'h3, 360, 0, 0, 0);
    n_total++; if (pulses !== 8) $display("FAIL timeout_pulses: got %0d expected 8", pulses); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL timeout_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== 320) $display("FAIL timeout_done_cyc: got %0d expected 320", done_cyc); else n_pass++;
    n_total++; if (res_at_done !== 32'h8008_01FF) $display("FAIL timeout_result: got %h expected 800801ff", res_at_done); else n_pass++;
    n_total++; if (rs_seen !== 0) $display("FAIL timeout_rs_forced: got %0d rs-high cycles expected 0", rs_seen); else n_pass++;
  endtask

  task automatic test_poll_boundary;
    fill_db(8'h80, 7, 8'h00);
    run_read(32'h2, 360, 0, 0, 0);
    n_total++; if (pulses !== 8) $display("FAIL boundary_pulses: got %0d expected 8", pulses); else n_pass++;
    n_total++; if (res_at_done !== 32'h0008_0000) $display("FAIL boundary_result: got %h expected 00080000", res_at_done); else n_pass++;
  endtask

  task automatic test_stall;
    fill_db(8'h5A, 0, 8'h5A);
    run_read(32'h1, 50, 8, 5, 0);
    n_total++; if (en_vec !== 32'h003F_FFF0) $display("FAIL stall_en: got %h expected 003ffff0", en_vec); else n_pass++;
    n_total++; if (en_qual !== 13) $display("FAIL stall_en_width: got %0d expected 13", en_qual); else n_pass++;
    n_total++; if (done_vec !== 32'h0100_0000) $display("FAIL stall_done: got %h expected 01000000", done_vec); else n_pass++;
    n_total++; if (res_at_done !== 32'h0000_005A) $display("FAIL stall_result: got %h expected 0000005a", res_at_done); else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    int seen;
    fill_db(8'h41, 0, 8'h41);
    lcd_data_in = 8'h41;
    @(negedge clk);
    dataa = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (lcd_en !== 1'b1) $display("FAIL midrst_pre_en: got %b expected 1", lcd_en); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if ({lcd_en, lcd_rw, lcd_rs, lcd_bus_rd} !== 4'b0000)
      $display("FAIL midrst_pins: got %b expected 0000", {lcd_en, lcd_rw, lcd_rs, lcd_bus_rd}); else n_pass++;
    n_total++; if (result !== 32'h0) $display("FAIL midrst_result: got %h expected 00000000", result); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || lcd_en) seen++;
    end
    n_total++; if (seen !== 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); else n_pass++;
    fill_db(8'h3C, 0, 8'h3C);
    run_read(32'h1, 40, 0, 0, 0);
    n_total++; if (en_vec !== 32'h0001_FFF0) $display("FAIL midrst_next_en: got %h expected 0001fff0", en_vec); else n_pass++;
    n_total++; if (done_cyc !== 19) $display("FAIL midrst_next_done_cyc: got %0d expected 19", done_cyc); else n_pass++;
    n_total++; if (res_at_done !== 32'h0000_003C) $display("FAIL midrst_next_result: got %h expected 0000003c", res_at_done); else n_pass++;
  endtask

  task automatic test_ignored_start;
    fill_db(8'h41, 0, 8'h41);
    run_read(32'h1, 80, 0, 0, 8);
    n_total++; if (pulses !== 1) $display("FAIL ignstart_pulses: got %0d expected 1", pulses); else n_pass++;
    n_total++; if (done_cnt !== 1) $display("FAIL ignstart_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_total++; if (done_cyc !== 19) $display("FAIL ignstart_done_cyc: got %0d expected 19", done_cyc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_busy_poll();
    test_timeout();
    test_poll_boundary();
    test_stall();
    test_single_read();
    test_reset_mid_read();
    test_ignored_start();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
